// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// mem_stage_ctrl : M-stage data-memory controller with req/ack handshake,
//                  upstream stall generation and the M->W pipeline register.
// Revision 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic              MemtoRegM,
  input  logic              RegWriteM,
  input  logic              sracc_selM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] finalRD3M,
  input  logic [4:0]        WriteRegM,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              RegWriteW,
  output logic [4:0]        WriteRegW,
  output logic [DATA_W-1:0] ResultW,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fault_q;
  logic              regwrite_q;
  logic [4:0]        writereg_q;
  logic [DATA_W-1:0] result_q;
  logic              memop;
  logic              misaligned;
  logic [DATA_W-1:0] result_d;

  assign memop      = MemWriteM | MemtoRegM;
  assign misaligned = memop & (ALUOutM[1:0] != 2'b00);

  assign mem_addr  = {ALUOutM[DATA_W-1:2], 2'b00};
  assign mem_wdata = WriteDataM;
  assign mem_we    = MemWriteM;

  assign result_d = MemtoRegM  ? mem_rdata :
                    sracc_selM ? finalRD3M : ALUOutM;

  // Handshake outputs must react to mem_ack in the same cycle, so they are
  // decoded here; everything that persists lives in the always_ff below.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_req = 1'b0;
    StallM  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (memop) begin
          if (misaligned) begin
            StallM  = 1'b1;
            state_d = S_FAULT;
          end else begin
            mem_req = 1'b1;
            if (!mem_ack) begin
              StallM  = 1'b1;
              cnt_d   = 8'd1;
              state_d = (cnt_d >= C_TIMEOUT) ? S_FAULT : S_BUSY;
            end
          end
        end
      end
      S_BUSY: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          StallM = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_d >= C_TIMEOUT) state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        StallM = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (reset) begin
      mem_req = 1'b0;
      StallM  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      fault_q    <= 1'b0;
      regwrite_q <= 1'b0;
      writereg_q <= 5'd0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= (state_d == S_FAULT);
      if (StallM) begin
        // Bubble into W: destination and value are held, only the enable drops.
        regwrite_q <= 1'b0;
      end else begin
        regwrite_q <= RegWriteM;
        writereg_q <= WriteRegM;
        result_q   <= result_d;
      end
    end
  end

  assign RegWriteW = regwrite_q;
  assign WriteRegW = writereg_q;
  assign ResultW   = result_q;
  assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_ctrl : randomized self-checking bench for mem_stage_ctrl
//                     using a transaction-level model of each M-stage op.
// Revision 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWriteM, MemtoRegM, RegWriteM, sracc_selM;
  logic [DW-1:0] ALUOutM, WriteDataM, finalRD3M, mem_rdata;
  logic [4:0]    WriteRegM;
  logic          mem_ack;
  logic          StallM, mem_req, mem_we, RegWriteW, fault;
  logic [DW-1:0] mem_addr, mem_wdata, ResultW;
  logic [4:0]    WriteRegW;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [4:0]    last_wr;
  logic [DW-1:0] last_res;

  mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
    .sracc_selM(sracc_selM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .finalRD3M(finalRD3M), .WriteRegM(WriteRegM),
    .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle_inputs();
    MemWriteM = 1'b0; MemtoRegM = 1'b0; RegWriteM = 1'b0; sracc_selM = 1'b0;
    ALUOutM = '0; WriteDataM = '0; finalRD3M = '0; WriteRegM = 5'd0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    MemtoRegM = 1'b1; ALUOutM = 32'h40; mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({mem_req, StallM} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_comb: req/stall=%b required 00", {mem_req, StallM});
      end
      @(posedge clk); #1;
      n_checks++;
      if ({RegWriteW, WriteRegW, ResultW, fault} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_regs: rw=%b wr=%0d res=%h fault=%b required 0/0/0/0",
                 RegWriteW, WriteRegW, ResultW, fault);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    set_idle_inputs();
    RegWriteM = 1'b0;
    last_wr  = 5'd0;
    last_res = '0;
    // One idle commit so the model tracks the W register from a known value.
    @(posedge clk); #1;
  endtask

  // kind: 0 = ALU, 1 = load, 2 = store. lat = request cycle carrying the ack.
  task automatic run_op(input int kind, input int lat, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input logic [DW-1:0] fin, input logic rw, input logic sra,
                        input logic [4:0] wr);
    logic          is_mem;
    logic [DW-1:0] exp_res;
    is_mem  = (kind != 0);
    exp_res = (kind == 1) ? rdata : (sra ? fin : addr);
    @(negedge clk);
    MemWriteM = (kind == 2); MemtoRegM = (kind == 1); RegWriteM = rw;
    sracc_selM = sra; ALUOutM = addr; WriteDataM = wdata; finalRD3M = fin;
    WriteRegM = wr;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      mem_ack   = is_mem ? (k == lat) : 1'($urandom_range(0, 1));
      mem_rdata = (k == lat) ? rdata : $urandom;
      #1;
      n_checks++;
      if ({mem_req, StallM} !== {is_mem, (k < lat)}) begin
        n_fail++;
        $display("FAIL op_handshake k=%0d kind=%0d: req/stall=%b required %b",
                 k, kind, {mem_req, StallM}, {is_mem, (k < lat)});
      end
      if (is_mem) begin
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {(kind == 2), {addr[DW-1:2], 2'b00}, wdata}) begin
          n_fail++;
          $display("FAIL op_bus k=%0d: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                   k, mem_we, mem_addr, mem_wdata, (kind == 2), addr, wdata);
        end
      end
      @(posedge clk); #1;
      if (k < lat) begin
        n_checks++;
        if ({RegWriteW, WriteRegW, ResultW} !== {1'b0, last_wr, last_res}) begin
          n_fail++;
          $display("FAIL op_bubble k=%0d: rw=%b wr=%0d res=%h required 0/%0d/%h",
                   k, RegWriteW, WriteRegW, ResultW, last_wr, last_res);
        end
      end else begin
        n_checks++;
        if ({RegWriteW, WriteRegW, ResultW} !== {rw, wr, exp_res}) begin
          n_fail++;
          $display("FAIL op_commit kind=%0d: rw=%b wr=%0d res=%h required %b/%0d/%h",
                   kind, RegWriteW, WriteRegW, ResultW, rw, wr, exp_res);
        end
        last_wr  = wr;
        last_res = exp_res;
      end
    end
  endtask

  task automatic test_directed();
    run_op(0, 1, 32'h1234, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd5);
    run_op(1, 1, 32'h40, 32'h0, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0, 5'd7);
    run_op(2, 3, 32'h80, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 1'b0, 5'd9);
    run_op(0, 1, 32'h55, 32'h0, 32'h0, 32'h600DF00D, 1'b1, 1'b1, 5'd3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      int kind, lat;
      logic [DW-1:0] a;
      kind = $urandom_range(0, 2);
      lat  = (kind == 0) ? 1 : $urandom_range(1, TO);
      a    = $urandom;
      if (kind != 0) a[1:0] = 2'b00;
      run_op(kind, lat, a, $urandom, $urandom, $urandom,
             (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    set_idle_inputs();
    MemtoRegM = 1'b1; RegWriteM = 1'b1; ALUOutM = 32'h100; WriteRegM = 5'd4;
    for (int k = 1; k <= TO; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      n_checks++;
      if ({mem_req, StallM, fault} !== 3'b110) begin
        n_fail++;
        $display("FAIL timeout_wait k=%0d: req/stall/fault=%b required 110",
                 k, {mem_req, StallM, fault});
      end
      @(posedge clk); #1;
      n_checks++;
      if (fault !== (k == TO)) begin
        n_fail++;
        $display("FAIL timeout_fault k=%0d: fault=%b required %b", k, fault, (k == TO));
      end
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1;
    n_checks++;
    if ({mem_req, StallM} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_late_ack: req/stall=%b required 01", {mem_req, StallM});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({RegWriteW, fault, ResultW} !== {1'b0, 1'b1, last_res}) begin
      n_fail++;
      $display("FAIL timeout_sticky: rw=%b fault=%b res=%h required 0/1/%h",
               RegWriteW, fault, ResultW, last_res);
    end
    test_reset();
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    set_idle_inputs();
    MemtoRegM = 1'b1; RegWriteM = 1'b1; ALUOutM = 32'h42; WriteRegM = 5'd8;
    #1;
    n_checks++;
    if ({mem_req, StallM} !== 2'b01) begin
      n_fail++;
      $display("FAIL misaligned_comb: req/stall=%b required 01", {mem_req, StallM});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({fault, RegWriteW} !== 2'b10) begin
      n_fail++;
      $display("FAIL misaligned_fault: fault/rw=%b required 10", {fault, RegWriteW});
    end
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, StallM} !== 2'b01) begin
      n_fail++;
      $display("FAIL misaligned_hold: req/stall=%b required 01", {mem_req, StallM});
    end
    test_reset();
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    set_idle_inputs();
    MemtoRegM = 1'b1; RegWriteM = 1'b1; ALUOutM = 32'h100; WriteRegM = 5'd6;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, StallM} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_reset_comb: req/stall=%b required 00", {mem_req, StallM});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({RegWriteW, fault} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_reset_regs: rw/fault=%b required 00", {RegWriteW, fault});
    end
    @(negedge clk);
    reset = 1'b0;
    set_idle_inputs();
    ALUOutM = 32'h77; WriteRegM = 5'd2;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    n_checks++;
    if ({mem_req, StallM} !== 2'b00) begin
      n_fail++;
      $display("FAIL stale_ack: req/stall=%b required 00", {mem_req, StallM});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({RegWriteW, ResultW} !== {1'b0, 32'h77}) begin
      n_fail++;
      $display("FAIL stale_ack_commit: rw=%b res=%h required 0/00000077", RegWriteW, ResultW);
    end
    last_wr  = 5'd2;
    last_res = 32'h77;
    run_op(1, 1, 32'h200, 32'h0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 5'd11);
  endtask

  initial begin
    set_idle_inputs();
    reset    = 1'b1;
    last_wr  = 5'd0;
    last_res = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_timeout();
    test_misaligned();
    test_reset_mid_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller that consumes the E→M pipeline register outputs and performs the M-stage data-memory access. It drives a variable-latency data memory through a req/ack handshake and stalls the upstream pipeline (F/D/E and the E→M register) while the access is outstanding. It also owns the M→W pipeline register, including the writeback result mux.

Parameters:
DATA_W, 32, data and address width.
TIMEOUT, 16, maximum cycles a request may wait for mem_ack before a bus fault is declared (1..255).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
MemWriteM  in  1  store in M stage
MemtoRegM  in  1  load in M stage
RegWriteM  in  1  M instruction writes the register file
sracc_selM  in  1  result comes from finalRD3M
ALUOutM  in  DATA_W  effective address or ALU result
WriteDataM  in  DATA_W  store data
finalRD3M  in  DATA_W  third-operand result path
WriteRegM  in  5  destination register
StallM  out  1  freeze upstream stages and the E→M register
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  DATA_W  word-aligned address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  access complete (single cycle)
RegWriteW  out  1  M→W register: write enable
WriteRegW  out  5  M→W register: destination
ResultW  out  DATA_W  M→W register: writeback value
fault  out  1  sticky bus fault (timeout or misaligned access)

Behaviour:
- Reset is synchronous and active-high. Clock and reset ports are named clk and reset.
- On reset: state=IDLE, wait counter=0, RegWriteW=0, WriteRegW=0, ResultW=0, fault=0. During any cycle in which reset=1, mem_req=0 and StallM=0.
- memop = MemWriteM | MemtoRegM. misaligned = memop & (ALUOutM[1:0] != 0).
- mem_addr = {ALUOutM[DATA_W-1:2], 2'b00}; mem_wdata = WriteDataM; mem_we = MemWriteM. These outputs are combinational from the M inputs, which stay stable while StallM=1.
- FSM states:
  - IDLE
    - memop & misaligned: mem_req=0, StallM=1, next state FAULT.
    - memop & !misaligned: mem_req=1. If mem_ack is high in the same cycle (zero-wait), the access completes: StallM=0 and the state stays IDLE. Otherwise StallM=1, counter←1, next state BUSY.
    - !memop: mem_req=0, StallM=0. mem_ack is ignored.
  - BUSY
    - mem_req=1 and held stable.
    - On mem_ack: StallM=0, counter←0, next state IDLE.
    - On !mem_ack: StallM=1, counter+1. If the counter reaches TIMEOUT without an ack, next state FAULT.
  - FAULT
    - mem_req=0, StallM=1 permanently, fault=1. Exit is by reset only; mem_ack is ignored.
- M→W register updates at every posedge:
  - StallM=1: insert a bubble. RegWriteW←0; WriteRegW and ResultW hold their values.
  - StallM=0: RegWriteW←RegWriteM, WriteRegW←WriteRegM, ResultW←MemtoRegM ? mem_rdata : (sracc_selM ? finalRD3M : ALUOutM).
- Back-to-back memory ops with no stall between them are legal. mem_req stays high across the boundary, and each mem_ack completes exactly one op.
- A store with RegWriteM=0 produces RegWriteW=0 on completion.
- An unsolicited mem_ack (no request outstanding) is ignored.
- Reset asserted while in BUSY: the state returns to IDLE, mem_req drops in the reset cycle, and any later ack for the aborted request is ignored.

Test Plan:
- ALU op, no memop: ALUOutM=0x1234, RegWriteM=1, WriteRegM=5 → StallM=0; next edge RegWriteW=1, WriteRegW=5, ResultW=0x1234.
- Zero-wait load: MemtoRegM=1, ALUOutM=0x40, mem_ack tied to mem_req, mem_rdata=0xCAFEF00D → mem_addr=0x40, mem_we=0, no stall; ResultW=0xCAFEF00D after one edge.
- 3-cycle-latency store: MemWriteM=1, ALUOutM=0x80, WriteDataM=0xA5A5A5A5, ack on the 3rd request cycle → StallM=1 for exactly 2 cycles with bubbles (RegWriteW=0); mem_req, mem_we, mem_addr and mem_wdata are stable throughout; completes with RegWriteW=0.
- Timeout: load with no ack, TIMEOUT=16 → StallM stays high and fault=1 after 16 waiting cycles; mem_req=0 afterwards; a late ack has no effect; reset clears fault.
- Misaligned load, ALUOutM=0x42 → mem_req never asserts; fault=1 the next cycle; StallM=1.
- Reset mid-BUSY, then a new aligned load with an immediate ack → the stale ack is ignored; the new load returns the correct data; RegWriteW=0 throughout reset.
